// File: rtl/qpsk_symbol_gen_if.sv
// Symbol-generator control and status bundle: control in, symbol/debug state out.
// All outputs are registered inside the generator; en pauses it with no lost count.
interface qpsk_symbol_gen_if;
    logic        en;
    logic [1:0]  mode;
    logic [1:0]  fixed_iq;
    logic [1:0]  IQ;
    logic        sym_strobe;
    logic [15:0] sym_count;
    logic [4:0]  lfsr_i;
    logic [4:0]  lfsr_q;

    modport master (
        output en, mode, fixed_iq,
        input  IQ, sym_strobe, sym_count, lfsr_i, lfsr_q
    );

    modport slave (
        input  en, mode, fixed_iq,
        output IQ, sym_strobe, sym_count, lfsr_i, lfsr_q
    );
endinterface

// File: rtl/qpsk_symbol_gen.sv
// QPSK symbol source (PRBS / fixed / walk), one symbol per BAUD_DIV enabled clocks.
// IQ and sym_strobe update one cycle after a tick; en low pauses the baud counter.
module qpsk_symbol_gen #(
    parameter int unsigned BAUD_DIV = 16666667,
    parameter logic [4:0]  SEED_I   = 5'b00001,
    parameter logic [4:0]  SEED_Q   = 5'b10101
) (
    input  logic               clk,
    input  logic               reset,
    qpsk_symbol_gen_if.slave   bus
);

    localparam logic [31:0] LAST = 32'(BAUD_DIV - 1);

    logic [31:0] cnt_q, cnt_d;
    logic [1:0]  iq_q, iq_d;
    logic        strobe_q, strobe_d;
    logic [15:0] count_q, count_d;
    logic [4:0]  lfsr_i_q, lfsr_i_d;
    logic [4:0]  lfsr_q_q, lfsr_q_d;
    logic        tick;

    // x^5+x^3+1 Fibonacci step; an all-zero state reloads the seed.
    function automatic logic [4:0] lfsr_step(input logic [4:0] s, input logic [4:0] seed);
        if (s == 5'd0)
            return seed;
        return {s[0] ^ s[2], s[4:1]};
    endfunction

    always_comb begin
        tick     = bus.en && (cnt_q == LAST);
        cnt_d    = cnt_q;
        iq_d     = iq_q;
        strobe_d = 1'b0;
        count_d  = count_q;
        lfsr_i_d = lfsr_i_q;
        lfsr_q_d = lfsr_q_q;

        if (bus.en)
            cnt_d = tick ? 32'd0 : cnt_q + 32'd1;

        // mode and fixed_iq only matter on the tick, so a mid-symbol switch waits.
        if (tick) begin
            strobe_d = 1'b1;
            count_d  = count_q + 16'd1;
            case (bus.mode)
                2'd0: begin
                    iq_d     = {lfsr_i_q[0], lfsr_q_q[0]};
                    lfsr_i_d = lfsr_step(lfsr_i_q, SEED_I);
                    lfsr_q_d = lfsr_step(lfsr_q_q, SEED_Q);
                end
                2'd2:    iq_d = iq_q + 2'd1;
                default: iq_d = bus.fixed_iq;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q    <= 32'd0;
            iq_q     <= 2'd0;
            strobe_q <= 1'b0;
            count_q  <= 16'd0;
            lfsr_i_q <= SEED_I;
            lfsr_q_q <= SEED_Q;
        end else begin
            cnt_q    <= cnt_d;
            iq_q     <= iq_d;
            strobe_q <= strobe_d;
            count_q  <= count_d;
            lfsr_i_q <= lfsr_i_d;
            lfsr_q_q <= lfsr_q_d;
        end
    end

    assign bus.IQ         = iq_q;
    assign bus.sym_strobe = strobe_q;
    assign bus.sym_count  = count_q;
    assign bus.lfsr_i     = lfsr_i_q;
    assign bus.lfsr_q     = lfsr_q_q;

endmodule

// File: tb/tb_qpsk_symbol_gen.sv
module tb_qpsk_symbol_gen;
    localparam int unsigned BD = 4;
    localparam logic [4:0] SI = 5'b00001;
    localparam logic [4:0] SQ = 5'b10101;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    qpsk_symbol_gen_if bus ();

    qpsk_symbol_gen #(.BAUD_DIV(BD), .SEED_I(SI), .SEED_Q(SQ)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;

    // Reference: LFSR output bit streams obey b[k+5] = b[k] ^ b[k+2];
    // the state after n steps is bits n..n+4 of the stream.
    bit bi[2048];
    bit bq[2048];
    int n, ecnt, mcount;
    logic [1:0] miq;
    logic mstrobe;
    logic [1:0] strobe_iq[$];

    function automatic logic [4:0] st_i(input int k);
        logic [4:0] r;
        for (int j = 0; j < 5; j++) r[j] = bi[k + j];
        return r;
    endfunction

    function automatic logic [4:0] st_q(input int k);
        logic [4:0] r;
        for (int j = 0; j < 5; j++) r[j] = bq[k + j];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("sym_strobe", {31'd0, bus.sym_strobe}, {31'd0, mstrobe});
        chk("IQ", {30'd0, bus.IQ}, {30'd0, miq});
        chk("sym_count", {16'd0, bus.sym_count}, 32'(mcount));
        chk("lfsr_i", {27'd0, bus.lfsr_i}, {27'd0, st_i(n)});
        chk("lfsr_q", {27'd0, bus.lfsr_q}, {27'd0, st_q(n)});
    endtask

    task automatic model_reset();
        n = 0; ecnt = 0; mcount = 0; miq = 2'd0; mstrobe = 1'b0;
    endtask

    task automatic cyc();
        logic e;
        logic [1:0] m, f;
        e = bus.en; m = bus.mode; f = bus.fixed_iq;
        @(posedge clk);
        #1;
        mstrobe = 1'b0;
        if (e) begin
            ecnt++;
            if (ecnt == int'(BD)) begin
                ecnt = 0;
                mstrobe = 1'b1;
                mcount = (mcount + 1) % 65536;
                if (m == 2'd0) begin
                    miq = {bi[n], bq[n]};
                    n++;
                end else if (m == 2'd2) begin
                    miq = 2'((int'(miq) + 1) % 4);
                end else begin
                    miq = f;
                end
            end
        end
        if (bus.sym_strobe) strobe_iq.push_back(bus.IQ);
        check_all();
    endtask

    task automatic run(input int k);
        repeat (k) cyc();
    endtask

    task automatic do_reset();
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        check_all();
        reset = 1'b0;
    endtask

    task automatic wait_strobe(input string tag, output int w);
        w = 0;
        do begin
            cyc();
            w++;
        end while (!bus.sym_strobe && w < 40);
        chk(tag, {31'd0, bus.sym_strobe}, 32'd1);
    endtask

    initial begin
        int w;
        bit seen_zero;
        for (int j = 0; j < 5; j++) begin
            bi[j] = SI[j];
            bq[j] = SQ[j];
        end
        for (int k = 0; k + 5 < 2048; k++) begin
            bi[k + 5] = bi[k] ^ bi[k + 2];
            bq[k + 5] = bq[k] ^ bq[k + 2];
        end

        // Reset values
        reset = 1'b1;
        bus.en = 1'b0; bus.mode = 2'd0; bus.fixed_iq = 2'd0;
        model_reset();
        #3;
        check_all();
        chk("rst_IQ", {30'd0, bus.IQ}, 32'd0);
        chk("rst_lfsr_i", {27'd0, bus.lfsr_i}, 32'b00001);
        chk("rst_lfsr_q", {27'd0, bus.lfsr_q}, 32'b10101);
        @(posedge clk);
        #1 reset = 1'b0;

        // PRBS: first symbols 3,0,1, known LFSR states, period 31
        bus.en = 1'b1; bus.mode = 2'd0;
        run(3 * BD);
        chk("prbs_sym0", {30'd0, strobe_iq[0]}, 32'd3);
        chk("prbs_sym1", {30'd0, strobe_iq[1]}, 32'd0);
        chk("prbs_sym2", {30'd0, strobe_iq[2]}, 32'd1);
        chk("prbs_lfsr_i_3", {27'd0, bus.lfsr_i}, 32'b00100);
        chk("prbs_lfsr_q_3", {27'd0, bus.lfsr_q}, 32'b00010);
        run(31 * BD);
        chk("prbs_period_i", {27'd0, bus.lfsr_i}, 32'b00100);
        chk("prbs_period_q", {27'd0, bus.lfsr_q}, 32'b00010);
        chk("prbs_repeat", {30'd0, strobe_iq[31]}, {30'd0, strobe_iq[0]});

        // Pause mid-symbol for 10 cycles
        run(2);
        bus.en = 1'b0;
        run(10);
        bus.en = 1'b1;
        wait_strobe("pause_strobe", w);
        chk("pause_spacing", 32'(12 + w), 32'd14);

        // Walk from IQ = 0
        bus.mode = 2'd1; bus.fixed_iq = 2'd0;
        run(BD);
        chk("walk_start", {30'd0, bus.IQ}, 32'd0);
        bus.mode = 2'd2;
        for (int s = 1; s <= 4; s++) begin
            run(BD);
            chk("walk_step", {30'd0, bus.IQ}, 32'(s % 4));
        end

        // Fixed mode switched mid-symbol takes effect only at the next strobe
        run(2);
        bus.mode = 2'd1; bus.fixed_iq = 2'd2;
        run(1);
        chk("fixed_hold", {30'd0, bus.IQ}, 32'd0);
        run(1);
        chk("fixed_apply", {30'd0, bus.IQ}, 32'd2);
        bus.mode = 2'd3; bus.fixed_iq = 2'd1;
        run(BD);
        chk("fixed_mode3", {30'd0, bus.IQ}, 32'd1);

        // Randomized enable, mode and fixed symbol
        repeat (400) begin
            bus.en = ($urandom_range(0, 3) != 0);
            bus.mode = 2'($urandom);
            bus.fixed_iq = 2'($urandom);
            cyc();
        end

        // Counter wrap: preload near the top, then run PRBS across it
        bus.en = 1'b1; bus.mode = 2'd0;
        force dut.count_q = 16'hFFFE;
        #1 release dut.count_q;
        mcount = 16'hFFFE;
        seen_zero = 1'b0;
        repeat (4 * BD) begin
            cyc();
            if (bus.sym_strobe && bus.sym_count == 16'd0) seen_zero = 1'b1;
        end
        chk("wrap_zero", {31'd0, seen_zero}, 32'd1);

        // Reset two cycles into a symbol
        wait_strobe("pre_reset_strobe", w);
        run(2);
        do_reset();
        bus.en = 1'b1; bus.mode = 2'd0;
        run(BD - 1);
        chk("post_reset_quiet", {31'd0, bus.sym_strobe}, 32'd0);
        run(1);
        chk("post_reset_strobe", {31'd0, bus.sym_strobe}, 32'd1);
        chk("post_reset_IQ", {30'd0, bus.IQ}, 32'd3);
        run(2 * BD);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
